brick_controller: RTL and testbench
===================================

// Module: brick_controller
// PURPOSE
//  Sequencer and arbiter for the single-port brick health RAM (256 x 2-bit, 1-cycle read).
//  Three clients share it: level init (fill every brick), ball-collision hits
//  (read-modify-write decrement) and the renderer (health lookup per brick).
//  Tracks live bricks and flags level clear. Sits between game FSM, collision and draw logic.
// PARAMETERS
//  COLS         16  bricks per row, 1..16; col index is 4 bits
//  ROWS         16  brick rows, 1..16; row index is 4 bits
//  INIT_HEALTH  3   health written to every in-range brick on init, 1..3
// PORTS
//  clk            in   1  clock
//  resetn         in   1  synchronous, active-low reset
//  init_start     in   1  request level fill; honoured only when idle
//  init_done      out  1  1-cycle pulse after last init write
//  busy           out  1  1 whenever state != IDLE
//  hit_req        in   1  collision hit request; accepted when hit_req & hit_ready at an edge
//  hit_ready      out  1  comb: IDLE & !init_start
//  hit_col/row    in   4  brick coordinates, held with hit_req
//  hit_done       out  1  1-cycle pulse, hit result valid
//  hit_health     out  2  health BEFORE the hit (0 = no brick)
//  hit_destroyed  out  1  with hit_done: brick went 1 -> 0
//  rd_req         in   1  renderer read request; accepted when rd_req & rd_ready
//  rd_ready       out  1  comb: IDLE & !init_start & !hit_req
//  rd_col/row     in   4  brick coordinates, held with rd_req
//  rd_valid       out  1  1-cycle pulse, rd_health valid
//  rd_health      out  2  stored health; holds until next rd_valid
//  bricks_left    out  9  live bricks, 0..256
//  level_clear    out  1  initialized & bricks_left == 0
//  mem_addr       out  8  RAM address = {row,col}
//  mem_data       out  2  RAM write data
//  mem_wren       out  1  RAM write enable
//  mem_q          in   2  RAM read data, valid the cycle after the address edge
// BEHAVIOUR
//  - Reset: state IDLE; every output reg 0 (init_done, hit_done, hit_health, hit_destroyed,
//    rd_valid, rd_health, bricks_left, mem_addr, mem_data, mem_wren, initialized=0).
//    Reset mid-operation aborts at once; RAM contents are not cleared; the level is re-inited.
//  - Priority in IDLE: init_start > hit_req > rd_req. No queuing; clients hold req until accepted.
//  - INIT: addr counter 0..255, one write per cycle (256 cycles). Data = INIT_HEALTH if
//    col < COLS and row < ROWS, else 0. After write 255: IDLE, init_done=1 for one cycle,
//    bricks_left = COLS*ROWS, initialized=1. init_start while busy is ignored.
//  - HIT (accept edge E0): HIT_RD drives latched address, wren=0; HIT_CHK captures mem_q
//    into hp at E2; HIT_WR writes hp-1 if hp != 0, no write if hp == 0.
//    Next cycle is IDLE with hit_done=1, hit_health=hp, hit_destroyed=(hp==1).
//    On destroy, bricks_left decrements in the same edge (no underflow below 0).
//    Out-of-range col/row: no RAM access, hit_health=0, hit_done same timing.
//  - RD (accept E0): RD_ADDR drives address; RD_CAP captures mem_q at E2.
//    rd_valid=1 in the following IDLE cycle. Out-of-range coordinates return 0.
//  - mem_wren is 1 only in INIT and in HIT_WR with hp != 0; mem_addr holds its last value otherwise.
//  - A new request may be accepted in the IDLE cycle carrying hit_done or rd_valid
//    (back-to-back hits every 4 cycles).
// TESTING
//  1. Reset, init_start 1 cycle -> busy 256 cycles, init_done once, bricks_left=256,
//     level_clear=0; RAM all 3.
//  2. rd (col 3,row 2) -> rd_valid 3 cycles after accept, rd_health=3, mem_addr=8'h23.
//  3. Three hits on (5,1) -> hit_health 3,2,1; hit_destroyed only on the 3rd; bricks_left 255.
//     A 4th hit -> hit_health=0, mem_wren never 1, bricks_left stays 255.
//  4. hit_req and rd_req high in the same IDLE cycle -> hit accepted first, rd_ready=0 until
//     hit_done; rd accepted next and returns post-hit health.
//  5. COLS=2, ROWS=1, INIT_HEALTH=1: init, hit (0,0), hit (1,0) -> level_clear=1;
//     a hit at col 4 returns hit_health=0.
//  6. resetn low at init cycle 100 -> next cycle IDLE, outputs 0, level_clear=0;
//     init_done never pulses for the aborted init.

Source files
------------

// File: rtl/brick_controller.sv
// Sequencer/arbiter for the single-port 256x2 brick health RAM: level fill,
// read-modify-write hit decrement and renderer lookups, plus live-brick tracking.
module brick_controller #(
  parameter int COLS        = 16,
  parameter int ROWS        = 16,
  parameter int INIT_HEALTH = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init_start_i,
  output logic       init_done_o,
  output logic       busy_o,
  input  logic       hit_req_i,
  output logic       hit_ready_o,
  input  logic [3:0] hit_col_i,
  input  logic [3:0] hit_row_i,
  output logic       hit_done_o,
  output logic [1:0] hit_health_o,
  output logic       hit_destroyed_o,
  input  logic       rd_req_i,
  output logic       rd_ready_o,
  input  logic [3:0] rd_col_i,
  input  logic [3:0] rd_row_i,
  output logic       rd_valid_o,
  output logic [1:0] rd_health_o,
  output logic [8:0] bricks_left_o,
  output logic       level_clear_o,
  output logic [7:0] mem_addr_o,
  output logic [1:0] mem_data_o,
  output logic       mem_wren_o,
  input  logic [1:0] mem_q_i
);

  localparam logic [8:0] TOTAL = 9'(COLS * ROWS);
  localparam logic [1:0] IH    = 2'(INIT_HEALTH);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_HIT_RD, S_HIT_CHK, S_HIT_WR, S_RD_ADDR, S_RD_CAP
  } state_e;

  state_e     state_q;
  logic [7:0] mem_addr_q;
  logic [1:0] mem_data_q;
  logic       mem_wren_q;
  logic       init_done_q;
  logic       hit_done_q;
  logic [1:0] hit_health_q;
  logic       hit_destroyed_q;
  logic       rd_valid_q;
  logic [1:0] rd_health_q;
  logic [8:0] bricks_left_q;
  logic       initialized_q;
  logic [1:0] hp_q;
  logic       oor_q;

  function automatic logic in_range(input logic [3:0] c, input logic [3:0] r);
    return (int'(c) < COLS) && (int'(r) < ROWS);
  endfunction

  logic [7:0] init_addr_d;
  logic [1:0] init_data_d;
  logic [1:0] hp_d;
  logic       hit_in_range;
  logic       rd_in_range;

  always_comb begin
    init_addr_d  = mem_addr_q + 8'd1;
    init_data_d  = in_range(init_addr_d[3:0], init_addr_d[7:4]) ? IH : 2'd0;
    // Out-of-range requests never touch the RAM, so ignore whatever mem_q holds.
    hp_d         = oor_q ? 2'd0 : mem_q_i;
    hit_in_range = in_range(hit_col_i, hit_row_i);
    rd_in_range  = in_range(rd_col_i, rd_row_i);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      mem_addr_q      <= 8'd0;
      mem_data_q      <= 2'd0;
      mem_wren_q      <= 1'b0;
      init_done_q     <= 1'b0;
      hit_done_q      <= 1'b0;
      hit_health_q    <= 2'd0;
      hit_destroyed_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_health_q     <= 2'd0;
      bricks_left_q   <= 9'd0;
      initialized_q   <= 1'b0;
      hp_q            <= 2'd0;
      oor_q           <= 1'b0;
    end else begin
      init_done_q <= 1'b0;
      hit_done_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_start_i) begin
            state_q       <= S_INIT;
            mem_addr_q    <= 8'd0;
            mem_data_q    <= IH;
            mem_wren_q    <= 1'b1;
            initialized_q <= 1'b0;
          end else if (hit_req_i) begin
            state_q <= S_HIT_RD;
            oor_q   <= !hit_in_range;
            if (hit_in_range) mem_addr_q <= {hit_row_i, hit_col_i};
          end else if (rd_req_i) begin
            state_q <= S_RD_ADDR;
            oor_q   <= !rd_in_range;
            if (rd_in_range) mem_addr_q <= {rd_row_i, rd_col_i};
          end
        end
        S_INIT: begin
          if (mem_addr_q == 8'hFF) begin
            state_q       <= S_IDLE;
            mem_wren_q    <= 1'b0;
            init_done_q   <= 1'b1;
            bricks_left_q <= TOTAL;
            initialized_q <= 1'b1;
          end else begin
            mem_addr_q <= init_addr_d;
            mem_data_q <= init_data_d;
          end
        end
        S_HIT_RD:  state_q <= S_HIT_CHK;
        S_HIT_CHK: begin
          state_q <= S_HIT_WR;
          hp_q    <= hp_d;
          if (hp_d != 2'd0) begin
            mem_wren_q <= 1'b1;
            mem_data_q <= hp_d - 2'd1;
          end
        end
        S_HIT_WR: begin
          state_q         <= S_IDLE;
          mem_wren_q      <= 1'b0;
          hit_done_q      <= 1'b1;
          hit_health_q    <= hp_q;
          hit_destroyed_q <= (hp_q == 2'd1);
          if (hp_q == 2'd1 && bricks_left_q != 9'd0)
            bricks_left_q <= bricks_left_q - 9'd1;
        end
        S_RD_ADDR: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          state_q     <= S_IDLE;
          rd_valid_q  <= 1'b1;
          rd_health_q <= oor_q ? 2'd0 : mem_q_i;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign hit_ready_o     = (state_q == S_IDLE) && !init_start_i;
  assign rd_ready_o      = (state_q == S_IDLE) && !init_start_i && !hit_req_i;
  assign init_done_o     = init_done_q;
  assign hit_done_o      = hit_done_q;
  assign hit_health_o    = hit_health_q;
  assign hit_destroyed_o = hit_destroyed_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_health_o     = rd_health_q;
  assign bricks_left_o   = bricks_left_q;
  assign level_clear_o   = initialized_q && (bricks_left_q == 9'd0);
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign mem_wren_o      = mem_wren_q;

endmodule

// File: tb/tb_brick_controller.sv
// Bench for brick_controller: a full-size and a 2x1 instance, each with its own RAM,
// checked against a per-brick health array model plus vector tables and hand sequences.
module tb_brick_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic       sel = 1'b0;
  logic       init_start = 1'b0, hit_req = 1'b0, rd_req = 1'b0;
  logic [3:0] hit_col = '0, hit_row = '0, rd_col = '0, rd_row = '0;

  logic [1:0] init_start_s, hit_req_s, rd_req_s;
  logic [1:0] init_done, busy, hit_ready, hit_done, hit_destroyed, rd_ready, rd_valid;
  logic [1:0] level_clear, mem_wren;
  logic [1:0] hit_health [2];
  logic [1:0] rd_health [2];
  logic [8:0] bricks_left [2];
  logic [7:0] mem_addr [2];
  logic [1:0] mem_data [2];
  logic [1:0] mem_q [2];
  logic [1:0] ram0 [256];
  logic [1:0] ram1 [256];

  assign init_start_s = {init_start & sel, init_start & ~sel};
  assign hit_req_s    = {hit_req & sel, hit_req & ~sel};
  assign rd_req_s     = {rd_req & sel, rd_req & ~sel};

  brick_controller dut0 (
    .clk(clk), .resetn(resetn),
    .init_start_i(init_start_s[0]), .init_done_o(init_done[0]), .busy_o(busy[0]),
    .hit_req_i(hit_req_s[0]), .hit_ready_o(hit_ready[0]), .hit_col_i(hit_col), .hit_row_i(hit_row),
    .hit_done_o(hit_done[0]), .hit_health_o(hit_health[0]), .hit_destroyed_o(hit_destroyed[0]),
    .rd_req_i(rd_req_s[0]), .rd_ready_o(rd_ready[0]), .rd_col_i(rd_col), .rd_row_i(rd_row),
    .rd_valid_o(rd_valid[0]), .rd_health_o(rd_health[0]), .bricks_left_o(bricks_left[0]),
    .level_clear_o(level_clear[0]), .mem_addr_o(mem_addr[0]), .mem_data_o(mem_data[0]),
    .mem_wren_o(mem_wren[0]), .mem_q_i(mem_q[0]));

  brick_controller #(.COLS(2), .ROWS(1), .INIT_HEALTH(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .init_start_i(init_start_s[1]), .init_done_o(init_done[1]), .busy_o(busy[1]),
    .hit_req_i(hit_req_s[1]), .hit_ready_o(hit_ready[1]), .hit_col_i(hit_col), .hit_row_i(hit_row),
    .hit_done_o(hit_done[1]), .hit_health_o(hit_health[1]), .hit_destroyed_o(hit_destroyed[1]),
    .rd_req_i(rd_req_s[1]), .rd_ready_o(rd_ready[1]), .rd_col_i(rd_col), .rd_row_i(rd_row),
    .rd_valid_o(rd_valid[1]), .rd_health_o(rd_health[1]), .bricks_left_o(bricks_left[1]),
    .level_clear_o(level_clear[1]), .mem_addr_o(mem_addr[1]), .mem_data_o(mem_data[1]),
    .mem_wren_o(mem_wren[1]), .mem_q_i(mem_q[1]));

  // 1-cycle synchronous RAMs, contents survive reset
  always @(posedge clk) begin
    if (mem_wren[0]) ram0[mem_addr[0]] <= mem_data[0];
    mem_q[0] <= ram0[mem_addr[0]];
    if (mem_wren[1]) ram1[mem_addr[1]] <= mem_data[1];
    mem_q[1] <= ram1[mem_addr[1]];
  end

  // Reference model: health per brick and live count, per instance
  int model [2][256];
  int m_left [2];
  bit m_init [2];
  int n_tests = 0, n_fail = 0;

  function automatic int cols_of(input bit s); return s ? 2 : 16; endfunction
  function automatic int rows_of(input bit s); return s ? 1 : 16; endfunction
  function automatic int ih_of(input bit s);   return s ? 1 : 3;  endfunction
  function automatic bit inr(input bit s, input int c, input int r);
    return c < cols_of(s) && r < rows_of(s);
  endfunction
  function automatic int ram_at(input bit s, input int a);
    return s ? int'(ram1[a]) : int'(ram0[a]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_zero_vec(input bit s);
    return {init_done[s], busy[s], hit_done[s], hit_health[s], hit_destroyed[s], rd_valid[s],
            rd_health[s], bricks_left[s], level_clear[s], mem_addr[s], mem_data[s], mem_wren[s]};
  endfunction

  task automatic model_hit(input int c, input int r, output int eh, output int ed);
    int a = r * 16 + c;
    eh = inr(sel, c, r) ? model[sel][a] : 0;
    ed = (eh == 1);
    if (eh != 0) model[sel][a]--;
    if (ed && m_left[sel] > 0) m_left[sel]--;
  endtask

  task automatic do_init();
    int n = 0, dc = 0;
    @(negedge clk); init_start = 1'b1;
    @(posedge clk); #1 init_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (init_done[sel]) dc++;
      if (!busy[sel]) break;
      n++;
    end
    @(negedge clk); if (init_done[sel]) dc++;
    chk("init_busy_cycles", n, 256);
    chk("init_done_pulses", dc, 1);
    for (int a = 0; a < 256; a++) model[sel][a] = inr(sel, a % 16, a / 16) ? ih_of(sel) : 0;
    m_left[sel] = cols_of(sel) * rows_of(sel);
    m_init[sel] = 1'b1;
    chk("init_bricks_left", bricks_left[sel], m_left[sel]);
    chk("init_level_clear", level_clear[sel], 0);
    n = 0;
    for (int a = 0; a < 256; a++) if (ram_at(sel, a) != model[sel][a]) n++;
    chk("init_ram_mismatches", n, 0);
  endtask

  // Issue one hit; returns health, destroyed flag, latency (cycles after accept) and writes seen
  task automatic do_hit(input int c, input int r, output int h, output int d,
                        output int lat, output int wr);
    lat = -1; wr = 0; h = -1; d = -1;
    @(negedge clk); hit_col = 4'(c); hit_row = 4'(r); hit_req = 1'b1;
    for (int i = 0; i < 20 && !hit_ready[sel]; i++) @(negedge clk);
    @(posedge clk); #1 hit_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_wren[sel]) wr++;
      if (hit_done[sel]) begin lat = k; h = hit_health[sel]; d = hit_destroyed[sel]; break; end
    end
  endtask

  task automatic do_rd(input int c, input int r, output int h, output int lat);
    lat = -1; h = -1;
    @(negedge clk); rd_col = 4'(c); rd_row = 4'(r); rd_req = 1'b1;
    for (int i = 0; i < 20 && !rd_ready[sel]; i++) @(negedge clk);
    @(posedge clk); #1 rd_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rd_valid[sel]) begin lat = k; h = rd_health[sel]; break; end
    end
  endtask

  // Model-checked operations
  task automatic hit_chk(input int c, input int r);
    int eh, ed, h, d, lat, wr;
    model_hit(c, r, eh, ed);
    do_hit(c, r, h, d, lat, wr);
    chk("hit_latency", lat, 4);
    chk("hit_health", h, eh);
    chk("hit_destroyed", d, ed);
    chk("hit_writes", wr, (eh != 0) ? 1 : 0);
    chk("hit_bricks_left", bricks_left[sel], m_left[sel]);
    chk("hit_level_clear", level_clear[sel], (m_init[sel] && m_left[sel] == 0) ? 1 : 0);
    if (inr(sel, c, r)) chk("hit_ram", ram_at(sel, r * 16 + c), model[sel][r * 16 + c]);
  endtask

  task automatic rd_chk(input int c, input int r);
    int h, lat;
    do_rd(c, r, h, lat);
    chk("rd_latency", lat, 3);
    chk("rd_health", h, inr(sel, c, r) ? model[sel][r * 16 + c] : 0);
    if (inr(sel, c, r)) chk("rd_mem_addr", mem_addr[sel], r * 16 + c);
  endtask

  typedef struct {
    bit is_hit;
    int c, r;
    int exp_h, exp_d, exp_left;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int h, d, lat, wr, eh, ed, bad;

    vecs[0] = '{1'b0, 3, 2, 3, 0, 256};
    vecs[1] = '{1'b1, 5, 1, 3, 0, 256};
    vecs[2] = '{1'b1, 5, 1, 2, 0, 256};
    vecs[3] = '{1'b1, 5, 1, 1, 1, 255};
    vecs[4] = '{1'b1, 5, 1, 0, 0, 255};
    vecs[5] = '{1'b0, 5, 1, 0, 0, 255};

    for (int a = 0; a < 256; a++) begin
      ram0[a] = 2'($urandom_range(0, 3));
      ram1[a] = 2'($urandom_range(0, 3));
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_dut0", out_zero_vec(1'b0), 0);
    chk("reset_outputs_dut1", out_zero_vec(1'b1), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_hit_ready", hit_ready[0], 1);
    init_start = 1'b1; #1;
    chk("hit_ready_blocked_by_init", hit_ready[0], 0);
    chk("rd_ready_blocked_by_init", rd_ready[0], 0);
    init_start = 1'b0;

    // Full-size fill, then the vector table
    sel = 1'b0;
    do_init();
    foreach (vecs[i]) begin
      if (vecs[i].is_hit) begin
        model_hit(vecs[i].c, vecs[i].r, eh, ed);
        do_hit(vecs[i].c, vecs[i].r, h, d, lat, wr);
        chk("vec_hit_latency", lat, 4);
        chk("vec_hit_health", h, vecs[i].exp_h);
        chk("vec_hit_destroyed", d, vecs[i].exp_d);
        chk("vec_hit_writes", wr, (vecs[i].exp_h != 0) ? 1 : 0);
      end else begin
        do_rd(vecs[i].c, vecs[i].r, h, lat);
        chk("vec_rd_latency", lat, 3);
        chk("vec_rd_health", h, vecs[i].exp_h);
        chk("vec_rd_mem_addr", mem_addr[0], vecs[i].r * 16 + vecs[i].c);
      end
      chk("vec_bricks_left", bricks_left[0], vecs[i].exp_left);
    end

    // Simultaneous hit and read: hit wins, read follows and sees the decrement
    @(negedge clk);
    hit_col = 4'd6; hit_row = 4'd2; hit_req = 1'b1;
    rd_col = 4'd6; rd_row = 4'd2; rd_req = 1'b1; #1;
    chk("arb_hit_ready", hit_ready[0], 1);
    chk("arb_rd_ready", rd_ready[0], 0);
    @(posedge clk); #1 hit_req = 1'b0;
    bad = 0; lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (hit_done[0]) begin lat = k; break; end
      if (rd_ready[0] || rd_valid[0]) bad++;
    end
    chk("arb_hit_latency", lat, 4);
    chk("arb_rd_held_off", bad, 0);
    chk("arb_hit_health", hit_health[0], 3);
    chk("arb_rd_ready_at_done", rd_ready[0], 1);
    model_hit(6, 2, eh, ed);
    @(posedge clk); #1 rd_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rd_valid[0]) begin lat = k; break; end
    end
    chk("arb_rd_latency", lat, 3);
    chk("arb_rd_health", rd_health[0], 2);

    // Randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0) hit_chk($urandom_range(0, 15), $urandom_range(0, 15));
      else rd_chk($urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Small level: clear it, then out-of-range hits and one past-clear hit
    sel = 1'b1;
    do_init();
    hit_chk(0, 0);
    hit_chk(1, 0);
    chk("small_level_clear", level_clear[1], 1);
    hit_chk(4, 0);
    chk("small_oor_health", hit_health[1], 0);
    hit_chk(0, 1);
    hit_chk(0, 0);
    chk("small_left_no_underflow", bricks_left[1], 0);
    rd_chk(1, 0);
    rd_chk(9, 9);

    // Reset in the middle of an init
    sel = 1'b0;
    @(negedge clk); init_start = 1'b1;
    @(posedge clk); #1 init_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_busy_before", busy[0], 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero", out_zero_vec(1'b0), 0);
    resetn = 1'b1;
    m_init[0] = 1'b0; m_left[0] = 0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (init_done[0]) bad++;
    end
    chk("abort_no_init_done", bad, 0);
    do_init();
    hit_chk(5, 1);
    rd_chk(5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
